// File: rtl/axi_sram_slave_pkg.sv
// Shared constants, FSM state types and burst helper for the AXI SRAM slave.
package axi_sram_slave_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // Byte step between beats; WRAP falls through as INCR.
  function automatic logic [7:0] beat_step(input logic [1:0] burst, input logic [2:0] size);
    case (burst)
      BURST_FIXED: return 8'd0;
      BURST_INCR:  return 8'd1 << size;
      default:     return 8'd1 << size;
    endcase
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between a master and the SRAM slave.
interface axi_sram_slave_if #(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int IW = 4,
  parameter int UW = 1
);
  logic          awvalid, awready, awlock;
  logic [AW-1:0] awaddr;
  logic [IW-1:0] awid;
  logic [7:0]    awlen;
  logic [2:0]    awsize, awprot;
  logic [1:0]    awburst;
  logic [UW-1:0] awuser;
  logic [3:0]    awcache, awqos;

  logic          wvalid, wready, wlast;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;

  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic [IW-1:0] bid;
  logic [UW-1:0] buser;

  logic          arvalid, arready, arlock;
  logic [AW-1:0] araddr;
  logic [IW-1:0] arid;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst;
  logic [UW-1:0] aruser;
  logic [3:0]    arcache, arqos;

  logic          rvalid, rready, rlast;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [IW-1:0] rid;
  logic [UW-1:0] ruser;

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, awprot, awuser, awlock, awcache, awqos,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid, buser,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, arprot, aruser, arlock, arcache, arqos,
    output arready,
    output rvalid, rdata, rresp, rlast, rid, ruser,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, awprot, awuser, awlock, awcache, awqos,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid, buser,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, arprot, aruser, arlock, arcache, arqos,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid, ruser,
    output rready
  );
endinterface

// File: rtl/axi_sram_slave_sram.sv
// Word array split into byte lanes: one combinational read port, one byte-enabled write port.
module sram_bytewrite #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4096,
  localparam int IDXW  = $clog2(DEPTH),
  localparam int NB    = DATA_W / 8
) (
  input  logic              clk,
  input  logic [IDXW-1:0]   i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_we,
  input  logic [IDXW-1:0]   i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [NB-1:0]     i_wr_be
);
  for (genvar g = 0; g < NB; g++) begin : g_lane
    logic [7:0] r_lane [DEPTH];

    always_ff @(posedge clk)
      if (i_we && i_wr_be[g]) r_lane[i_wr_idx] <= i_wr_data[g*8 +: 8];

    assign o_rd_data[g*8 +: 8] = r_lane[i_rd_idx];
  end
endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave over a byte-writable word SRAM; independent single-outstanding read and write FSMs.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int                        AXI_ADDR_WIDTH = 64,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter int                        AXI_ID_WIDTH   = 4,
  parameter int                        AXI_USER_WIDTH = 1,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE           = 64'h8000_0000,
  parameter int                        DEPTH          = 4096
) (
  input  logic            aclk,
  input  logic            aresetn,
  axi_sram_slave_if.slave s_axi
);
  localparam int AW   = AXI_ADDR_WIDTH;
  localparam int DW   = AXI_DATA_WIDTH;
  localparam int IW   = AXI_ID_WIDTH;
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [AW-1:0] LIMIT = BASE + (AW'(DEPTH) << 3);

  function automatic logic oor(input logic [AW-1:0] a);
    return (a < BASE) || (a >= LIMIT);
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [AW-1:0] a);
    return IDXW'((a - BASE) >> 3);
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [2:0] sz,
                                              input logic [1:0] bu);
    return a + AW'(beat_step(bu, sz));
  endfunction

  // ---------------- read side ----------------
  rd_state_e     r_rstate;
  logic          r_arready, r_rvalid, r_rlast;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_rresp, r_rburst;
  logic [IW-1:0] r_rid;
  logic [AW-1:0] r_raddr;
  logic [7:0]    r_rlen, r_rbeat;
  logic [2:0]    r_rsize;
  logic [AW-1:0] w_rd_addr;
  logic [DW-1:0] w_mem_rdata, w_rd_word;
  logic          w_rd_oor, w_ar_hs, w_r_hs;

  assign w_ar_hs   = s_axi.arvalid && r_arready;
  assign w_r_hs    = r_rvalid && s_axi.rready;
  // Beat loaded at the coming edge: burst start while idle, else the following beat.
  assign w_rd_addr = (r_rstate == R_IDLE) ? s_axi.araddr : next_addr(r_raddr, r_rsize, r_rburst);
  assign w_rd_oor  = oor(w_rd_addr);
  assign w_rd_word = w_rd_oor ? '0 : w_mem_rdata;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_rid     <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
      r_rsize   <= '0;
      r_rburst  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            r_raddr   <= s_axi.araddr;
            r_rid     <= s_axi.arid;
            r_rlen    <= s_axi.arlen;
            r_rsize   <= s_axi.arsize;
            r_rburst  <= s_axi.arburst;
            r_rbeat   <= '0;
            r_rvalid  <= 1'b1;
            r_rlast   <= (s_axi.arlen == 8'd0);
            r_rdata   <= w_rd_word;
            r_rresp   <= w_rd_oor ? RESP_DECERR : RESP_OKAY;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid  <= 1'b0;
              r_rlast   <= 1'b0;
              r_arready <= 1'b1;
              r_rstate  <= R_IDLE;
            end else begin
              r_raddr <= w_rd_addr;
              r_rbeat <= r_rbeat + 8'd1;
              r_rlast <= (r_rbeat + 8'd1 == r_rlen);
              r_rdata <= w_rd_word;
              r_rresp <= w_rd_oor ? RESP_DECERR : RESP_OKAY;
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  // ---------------- write side ----------------
  wr_state_e     r_wstate;
  logic          r_awready, r_wready, r_bvalid, r_wdec;
  logic [1:0]    r_bresp, r_wburst;
  logic [IW-1:0] r_bid;
  logic [AW-1:0] r_waddr;
  logic [7:0]    r_wlen, r_wbeat;
  logic [2:0]    r_wsize;
  logic          w_aw_hs, w_w_hs, w_wr_oor, w_wr_end, w_len_hit;

  assign w_aw_hs   = s_axi.awvalid && r_awready;
  assign w_w_hs    = s_axi.wvalid && r_wready;
  assign w_wr_oor  = oor(r_waddr);
  assign w_len_hit = (r_wbeat == r_wlen);
  assign w_wr_end  = s_axi.wlast || w_len_hit;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_bid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wbeat   <= '0;
      r_wsize   <= '0;
      r_wburst  <= '0;
      r_wdec    <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_awready <= 1'b1;
          if (w_aw_hs) begin
            r_awready <= 1'b0;
            r_waddr   <= s_axi.awaddr;
            r_bid     <= s_axi.awid;
            r_wlen    <= s_axi.awlen;
            r_wsize   <= s_axi.awsize;
            r_wburst  <= s_axi.awburst;
            r_wbeat   <= '0;
            r_wdec    <= 1'b0;
            r_wready  <= 1'b1;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            if (w_wr_end) begin
              // Decode error on any beat outranks a wlast/length disagreement.
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_wdec || w_wr_oor)        ? RESP_DECERR :
                          (s_axi.wlast != w_len_hit)  ? RESP_SLVERR : RESP_OKAY;
              r_wstate <= W_RESP;
            end else begin
              r_waddr <= next_addr(r_waddr, r_wsize, r_wburst);
              r_wbeat <= r_wbeat + 8'd1;
              r_wdec  <= r_wdec | w_wr_oor;
            end
          end
        end
        W_RESP: begin
          if (s_axi.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  sram_bytewrite #(.DATA_W(DW), .DEPTH(DEPTH)) u_sram (
    .clk       (aclk),
    .i_rd_idx  (word_idx(w_rd_addr)),
    .o_rd_data (w_mem_rdata),
    .i_we      (w_w_hs && !w_wr_oor),
    .i_wr_idx  (word_idx(r_waddr)),
    .i_wr_data (s_axi.wdata),
    .i_wr_be   (s_axi.wstrb)
  );

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.bid     = r_bid;
  assign s_axi.buser   = {AXI_USER_WIDTH{1'b0}};
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rlast   = r_rlast;
  assign s_axi.rid     = r_rid;
  assign s_axi.ruser   = {AXI_USER_WIDTH{1'b0}};

  // Sideband attributes carry no meaning for a flat SRAM.
  logic w_unused;
  assign w_unused = ^{s_axi.awprot, s_axi.awuser, s_axi.awlock, s_axi.awcache, s_axi.awqos,
                      s_axi.arprot, s_axi.aruser, s_axi.arlock, s_axi.arcache, s_axi.arqos};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed plus randomized bench for axi_sram_slave against a word-array reference model.
module tb_axi_sram_slave;
  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi_sram_slave_if #(.AW(64), .DW(64), .IW(4), .UW(1)) bus ();

  axi_sram_slave #(
    .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1),
    .BASE(BASE), .DEPTH(DEPTH)
  ) dut (.aclk(aclk), .aresetn(aresetn), .s_axi(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] mdl [int];
  logic [63:0] wq_data [$];
  logic [7:0]  wq_strb [$];
  logic        wq_last [$];
  logic [63:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_map(input logic [63:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'(((a - BASE) / 64'd8) % 64'(DEPTH));
  endfunction

  function automatic logic [63:0] baddr(input logic [63:0] a, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? a : a + 64'(i) * 64'd8;
  endfunction

  // Applies the queued beats to the model; returns the expected B response.
  function automatic logic [1:0] mdl_write(input logic [63:0] a, input logic [7:0] len,
                                           input logic [1:0] burst);
    int n = 0;
    bit dec = 0;
    while (!wq_last[n] && n != int'(len)) n++;
    for (int i = 0; i <= n; i++) begin
      logic [63:0] ba, w;
      ba = baddr(a, burst, i);
      if (!in_map(ba)) dec = 1;
      else begin
        w = mdl.exists(widx(ba)) ? mdl[widx(ba)] : 64'h0;
        for (int b = 0; b < 8; b++) if (wq_strb[i][b]) w[b*8 +: 8] = wq_data[i][b*8 +: 8];
        mdl[widx(ba)] = w;
      end
    end
    return dec ? 2'b11 : (wq_last[n] && n == int'(len)) ? 2'b00 : 2'b10;
  endfunction

  task automatic fill_wq(input logic [7:0] len, input bit rnd_strb);
    wq_data.delete(); wq_strb.delete(); wq_last.delete();
    for (int i = 0; i <= int'(len); i++) begin
      wq_data.push_back({$urandom, $urandom});
      wq_strb.push_back(rnd_strb ? 8'($urandom) : 8'hFF);
      wq_last.push_back(i == int'(len));
    end
  endtask

  task automatic do_write(input logic [63:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input string tag);
    logic [1:0] exp;
    int t;
    exp = mdl_write(a, len, burst);
    bus.awvalid = 1'b1; bus.awaddr = a; bus.awid = id; bus.awlen = len;
    bus.awsize = 3'd3; bus.awburst = burst; bus.awprot = 3'($urandom);
    t = 0;
    while (!bus.awready && t < 20) begin @(negedge aclk); t++; end
    chk({tag, "/aw_to"}, 64'(t < 20), 64'd1);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < wq_data.size(); i++) begin
      bus.wvalid = 1'b1; bus.wdata = wq_data[i]; bus.wstrb = wq_strb[i]; bus.wlast = wq_last[i];
      t = 0;
      while (!bus.wready && t < 20) begin @(negedge aclk); t++; end
      chk($sformatf("%s/w%0d_to", tag, i), 64'(t < 20), 64'd1);
      @(negedge aclk);
      if (wq_last[i] || i == int'(len)) break;
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.bready = ($urandom_range(0, 1) == 1);
    t = 0;
    while (!(bus.bvalid && bus.bready) && t < 20) begin @(negedge aclk); bus.bready = 1'b1; t++; end
    chk({tag, "/b_to"}, 64'(t < 20), 64'd1);
    chk({tag, "/bresp"}, 64'(bus.bresp), 64'(exp));
    chk({tag, "/bid"}, 64'(bus.bid), 64'(id));
    @(negedge aclk);
    bus.bready = 1'b0;
    chk({tag, "/bdone"}, 64'(bus.bvalid), 64'd0);
  endtask

  task automatic do_read(input logic [63:0] a, input logic [3:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle, input string tag);
    int t, beat;
    bit rr, tog, held_v;
    logic [63:0] held, ba, ed;
    bus.arvalid = 1'b1; bus.araddr = a; bus.arid = id; bus.arlen = len;
    bus.arsize = 3'd3; bus.arburst = burst; bus.arcache = 4'($urandom);
    t = 0;
    while (!bus.arready && t < 20) begin @(negedge aclk); t++; end
    chk({tag, "/ar_to"}, 64'(t < 20), 64'd1);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    beat = 0; t = 0; tog = 1'b1; held_v = 1'b0; held = '0;
    while (beat <= int'(len) && t < 100) begin
      rr = toggle ? tog : 1'b1;
      tog = !tog;
      bus.rready = rr;
      if (bus.rvalid) begin
        if (held_v) chk($sformatf("%s/hold%0d", tag, beat), bus.rdata, held);
        if (rr) begin
          ba = baddr(a, burst, beat);
          ed = in_map(ba) ? mdl[widx(ba)] : 64'h0;
          chk($sformatf("%s/rdata%0d", tag, beat), bus.rdata, ed);
          chk($sformatf("%s/rresp%0d", tag, beat), 64'(bus.rresp), in_map(ba) ? 64'd0 : 64'd3);
          chk($sformatf("%s/rlast%0d", tag, beat), 64'(bus.rlast), 64'(beat == int'(len)));
          chk($sformatf("%s/rid%0d", tag, beat), 64'(bus.rid), 64'(id));
          last_rdata = bus.rdata;
          beat++;
          held_v = 1'b0;
        end else begin
          held = bus.rdata;
          held_v = 1'b1;
        end
      end
      @(negedge aclk);
      t++;
    end
    bus.rready = 1'b0;
    chk({tag, "/r_to"}, 64'(t < 100), 64'd1);
    chk({tag, "/ridle"}, 64'({bus.rvalid, bus.arready}), 64'b01);
  endtask

  initial begin
    logic [63:0] a, old, nv;
    logic [7:0] len;
    logic [1:0] burst;
    int sel, t;

    bus.awvalid = 0; bus.awaddr = 0; bus.awid = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
    bus.awprot = 0; bus.awuser = 0; bus.awlock = 0; bus.awcache = 0; bus.awqos = 0;
    bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = 0; bus.arid = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
    bus.arprot = 0; bus.aruser = 0; bus.arlock = 0; bus.arcache = 0; bus.arqos = 0;
    bus.rready = 0;

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst/ctl", 64'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, bus.rlast}), 64'd0);
    chk("rst/resp", 64'({bus.bresp, bus.rresp}), 64'd0);
    chk("rst/rdata", bus.rdata, 64'd0);
    chk("rst/ids", 64'({bus.bid, bus.rid}), 64'd0);
    aresetn = 1'b1;
    #1 chk("rel/arready0", 64'({bus.arready, bus.awready}), 64'd0);
    @(negedge aclk);
    chk("rel/ready1", 64'({bus.arready, bus.awready}), 64'b11);

    // Preload words 0..31 and the two top words
    fill_wq(8'd31, 1'b0);
    do_write(BASE, 4'd1, 8'd31, 2'b01, "pre0");
    fill_wq(8'd1, 1'b0);
    do_write(LIMIT - 64'd16, 4'd2, 8'd1, 2'b01, "pre1");

    // Full-word write and readback
    fill_wq(8'd0, 1'b0);
    wq_data[0] = 64'h1122334455667788;
    do_write(BASE + 64'h8, 4'd3, 8'd0, 2'b01, "w_full");
    do_read(BASE + 64'h8, 4'd3, 8'd0, 2'b01, 1'b0, "r_full");
    chk("r_full/const", last_rdata, 64'h1122334455667788);

    // Partial strobe
    fill_wq(8'd0, 1'b0);
    wq_data[0] = 64'hAAAAAAAA_BBBBBBBB;
    wq_strb[0] = 8'h0F;
    do_write(BASE + 64'h8, 4'd4, 8'd0, 2'b01, "w_strb");
    do_read(BASE + 64'h8, 4'd4, 8'd0, 2'b01, 1'b0, "r_strb");
    chk("r_strb/const", last_rdata, 64'h11223344_BBBBBBBB);

    // INCR 4-beat read with rready toggling
    do_read(BASE, 4'd7, 8'd3, 2'b01, 1'b1, "r_incr4");

    // Below-base write: must not alias onto the top word
    old = mdl[DEPTH-1];
    fill_wq(8'd0, 1'b0);
    do_write(64'h7FFF_FFF8, 4'd5, 8'd0, 2'b01, "w_oor");
    do_read(LIMIT - 64'd8, 4'd0, 8'd0, 2'b01, 1'b0, "r_top");
    chk("r_top/unchanged", last_rdata, old);
    do_read(64'h7FFF_FFF8, 4'd5, 8'd0, 2'b01, 1'b0, "r_oor");

    // wlast early, and wlast missing at awlen
    fill_wq(8'd1, 1'b0);
    wq_last[0] = 1'b1;
    do_write(BASE + 64'h20, 4'd6, 8'd1, 2'b01, "w_early");
    fill_wq(8'd1, 1'b0);
    wq_last[1] = 1'b0;
    do_write(BASE + 64'h30, 4'd6, 8'd1, 2'b01, "w_nolast");

    // Read and write of the same word on the same edge
    old = mdl[3];
    nv = {$urandom, $urandom};
    bus.awvalid = 1'b1; bus.awaddr = BASE + 64'd24; bus.awid = 4'd2; bus.awlen = 8'd0;
    bus.awsize = 3'd3; bus.awburst = 2'b01;
    t = 0;
    while (!bus.awready && t < 20) begin @(negedge aclk); t++; end
    @(negedge aclk);
    bus.awvalid = 1'b0;
    chk("cc/ready", 64'({bus.wready, bus.arready}), 64'b11);
    bus.wvalid = 1'b1; bus.wdata = nv; bus.wstrb = 8'hFF; bus.wlast = 1'b1;
    bus.arvalid = 1'b1; bus.araddr = BASE + 64'd24; bus.arid = 4'd6; bus.arlen = 8'd0;
    bus.arsize = 3'd3; bus.arburst = 2'b01;
    @(negedge aclk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
    chk("cc/rdata_old", bus.rdata, old);
    chk("cc/valids", 64'({bus.rvalid, bus.bvalid, bus.bresp}), 64'b1100);
    bus.rready = 1'b1; bus.bready = 1'b1;
    @(negedge aclk);
    bus.rready = 1'b0; bus.bready = 1'b0;
    mdl[3] = nv;
    do_read(BASE + 64'd24, 4'd6, 8'd0, 2'b01, 1'b0, "cc/after");

    // Randomized traffic
    for (int k = 0; k < 24; k++) begin
      len = 8'($urandom_range(0, 3));
      burst = ($urandom_range(0, 3) == 0) ? 2'b00 : (($urandom_range(0, 4) == 0) ? 2'b10 : 2'b01);
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = LIMIT - 64'd8 * 64'($urandom_range(1, 2));
      else if (sel == 1) a = BASE - 64'd8;
      else               a = BASE + 64'd8 * 64'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        fill_wq(len, 1'b1);
        if (len != 0 && $urandom_range(0, 5) == 0) wq_last[$urandom_range(0, int'(len) - 1)] = 1'b1;
        if ($urandom_range(0, 7) == 0) wq_last[len] = 1'b0;
        do_write(a, 4'($urandom), len, burst, $sformatf("rw%0d", k));
      end else begin
        do_read(a, 4'($urandom), len, burst, 1'($urandom), $sformatf("rr%0d", k));
      end
    end

    // Reset during beat 2 of an 8-beat read
    bus.arvalid = 1'b1; bus.araddr = BASE; bus.arid = 4'd9; bus.arlen = 8'd7;
    bus.arsize = 3'd3; bus.arburst = 2'b01;
    t = 0;
    while (!bus.arready && t < 20) begin @(negedge aclk); t++; end
    @(negedge aclk);
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    repeat (2) @(negedge aclk);
    chk("abort/beat2", bus.rdata, mdl[2]);
    aresetn = 1'b0;
    #1;
    chk("abort/rvalid", 64'({bus.rvalid, bus.rlast, bus.arready}), 64'd0);
    chk("abort/rdata", bus.rdata, 64'd0);
    chk("abort/rid", 64'(bus.rid), 64'd0);
    bus.rready = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    #1 chk("abort/rel0", 64'(bus.arready), 64'd0);
    @(negedge aclk);
    chk("abort/rel1", 64'({bus.arready, bus.rvalid}), 64'b10);
    do_read(BASE + 64'd16, 4'd1, 8'd0, 2'b01, 1'b0, "abort/kept");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
